// File: rtl/aw_addr_decoder_reg.sv
// rtl/aw_addr_decoder_reg.sv - registered AW address decoder with one-entry slice and route FIFO (optional macro: AW_DECERR_EN)
module aw_addr_decoder_reg #(
  parameter int NUM_MASTERS = 2,
  parameter int MASTER_ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 8,
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {2'd3, {(ADDR_W-2){1'b0}}, 2'd2, {(ADDR_W-2){1'b0}},
                                                        2'd1, {(ADDR_W-2){1'b0}}, 2'd0, {(ADDR_W-2){1'b0}}},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {NUM_SLAVES{{2'b11, {(ADDR_W-2){1'b0}}}}},
  parameter int ROUTE_DEPTH = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [MASTER_ID_W-1:0] S_awid,
  input  logic [ADDR_W-1:0]      S_awaddr,
  input  logic [LEN_W-1:0]       S_awlen,
  input  logic [2:0]             S_awsize,
  input  logic [1:0]             S_awburst,
  input  logic [1:0]             S_awlock,
  input  logic [3:0]             S_awcache,
  input  logic [2:0]             S_awprot,
  input  logic [3:0]             S_awqos,
  input  logic                   S_awvalid,
  output logic                   S_awready,
  output logic [MASTER_ID_W-1:0] M_awid,
  output logic [ADDR_W-1:0]      M_awaddr,
  output logic [LEN_W-1:0]       M_awlen,
  output logic [2:0]             M_awsize,
  output logic [1:0]             M_awburst,
  output logic [1:0]             M_awlock,
  output logic [3:0]             M_awcache,
  output logic [2:0]             M_awprot,
  output logic [3:0]             M_awqos,
  output logic [NUM_SLAVES-1:0]  M_awvalid,
  input  logic [NUM_SLAVES-1:0]  M_awready,
  output logic [NUM_SLAVES-1:0]  Q_Enables,
  output logic                   route_valid,
  output logic [SEL_W-1:0]       route_sel,
  output logic                   route_decerr,
  output logic [MASTER_ID_W-1:0] route_id,
  input  logic                   route_pop,
  output logic                   decerr_valid,
  output logic [MASTER_ID_W-1:0] decerr_id
);

  localparam int PTR_W = (ROUTE_DEPTH > 1) ? $clog2(ROUTE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [SEL_W-1:0]       w_dec_sel;
  logic                   w_dec_err;
  logic                   w_drain;
  logic                   w_pop;
  logic                   w_accept;
  logic [NUM_SLAVES-1:0]  w_onehot;

  logic                   r_full;
  logic                   r_decerr;
  logic [SEL_W-1:0]       r_sel;
  logic [MASTER_ID_W-1:0] r_awid;
  logic [ADDR_W-1:0]      r_awaddr;
  logic [LEN_W-1:0]       r_awlen;
  logic [2:0]             r_awsize;
  logic [1:0]             r_awburst;
  logic [1:0]             r_awlock;
  logic [3:0]             r_awcache;
  logic [2:0]             r_awprot;
  logic [3:0]             r_awqos;

  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_cnt;
  logic [SEL_W-1:0]       r_fifo_sel [ROUTE_DEPTH];
  logic                   r_fifo_err [ROUTE_DEPTH];
  logic [MASTER_ID_W-1:0] r_fifo_id  [ROUTE_DEPTH];

  // Address decode: scan downwards so the lowest matching slot is the one left standing
  always_comb begin
    w_dec_sel = '0;
`ifdef AW_DECERR_EN
    w_dec_err = 1'b1;
`else
    w_dec_err = 1'b0;
`endif
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((S_awaddr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        w_dec_sel = SEL_W'(i);
        w_dec_err = 1'b0;
      end
    end
  end

  // A decode-error entry retires on its own; a mapped entry waits for its slave
  assign w_drain   = r_full && (r_decerr || M_awready[r_sel]);
  assign w_pop     = route_pop && (r_cnt != '0);
  assign S_awready = !ARESET && (!r_full || w_drain) &&
                     ((r_cnt < CNT_W'(ROUTE_DEPTH)) || w_pop);
  assign w_accept  = S_awvalid && S_awready;

  // Slice occupancy and payload; payload only changes on accept so it is stable while stalled
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_full    <= 1'b0;
      r_decerr  <= 1'b0;
      r_sel     <= '0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_awlock  <= '0;
      r_awcache <= '0;
      r_awprot  <= '0;
      r_awqos   <= '0;
    end else if (w_accept) begin
      r_full    <= 1'b1;
      r_decerr  <= w_dec_err;
      r_sel     <= w_dec_sel;
      r_awid    <= S_awid;
      r_awaddr  <= S_awaddr;
      r_awlen   <= S_awlen;
      r_awsize  <= S_awsize;
      r_awburst <= S_awburst;
      r_awlock  <= S_awlock;
      r_awcache <= S_awcache;
      r_awprot  <= S_awprot;
      r_awqos   <= S_awqos;
    end else if (w_drain) begin
      r_full    <= 1'b0;
    end
  end

  // One-hot target of the slice, silent for empty or decode-error entries
  always_comb begin
    w_onehot = '0;
    if (r_full && !r_decerr) begin
      w_onehot[r_sel] = 1'b1;
    end
  end

  assign M_awvalid    = w_onehot;
  assign Q_Enables    = w_onehot;
  assign M_awid       = r_awid;
  assign M_awaddr     = r_awaddr;
  assign M_awlen      = r_awlen;
  assign M_awsize     = r_awsize;
  assign M_awburst    = r_awburst;
  assign M_awlock     = r_awlock;
  assign M_awcache    = r_awcache;
  assign M_awprot     = r_awprot;
  assign M_awqos      = r_awqos;
  assign decerr_valid = r_full && r_decerr;
  assign decerr_id    = r_awid;

  // Route FIFO storage; entries are written in AW acceptance order
  always_ff @(posedge ACLK) begin
    if (w_accept) begin
      r_fifo_sel[r_wr_ptr] <= w_dec_sel;
      r_fifo_err[r_wr_ptr] <= w_dec_err;
      r_fifo_id[r_wr_ptr]  <= S_awid;
    end
  end

  // Route FIFO pointers and count; simultaneous push and pop leaves the count alone
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_accept && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_accept && w_pop) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign route_valid  = (r_cnt != '0);
  assign route_sel    = r_fifo_sel[r_rd_ptr];
  assign route_decerr = r_fifo_err[r_rd_ptr];
  assign route_id     = r_fifo_id[r_rd_ptr];

endmodule

// File: tb/tb_aw_addr_decoder_reg.sv
// tb/tb_aw_addr_decoder_reg.sv - randomized self-checking bench for aw_addr_decoder_reg against a transaction model
module tb_aw_addr_decoder_reg;

  localparam int DEPTH = 4;
  // slot0 0x0xxx_xxxx, slot1 0x4xxx_xxxx, slot2 0x8xxx_xxxx, slot3 0x8-0xF (overlaps slot2, loses on 0x8)
  localparam logic [127:0] TB_BASE = {32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [127:0] TB_MASK = {32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic [31:0] m_base [4] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] m_mask [4] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h8000_0000};

  logic        ACLK, ARESET;
  logic [0:0]  S_awid, M_awid, route_id, decerr_id;
  logic [31:0] S_awaddr, M_awaddr;
  logic [7:0]  S_awlen, M_awlen;
  logic [2:0]  S_awsize, M_awsize, S_awprot, M_awprot;
  logic [1:0]  S_awburst, M_awburst, S_awlock, M_awlock;
  logic [3:0]  S_awcache, M_awcache, S_awqos, M_awqos;
  logic        S_awvalid, S_awready;
  logic [3:0]  M_awvalid, M_awready, Q_Enables;
  logic        route_valid, route_decerr, route_pop, decerr_valid;
  logic [1:0]  route_sel;

  aw_addr_decoder_reg #(
    .SLAVE_BASE(TB_BASE),
    .SLAVE_MASK(TB_MASK),
    .ROUTE_DEPTH(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_awid(S_awid), .S_awaddr(S_awaddr), .S_awlen(S_awlen), .S_awsize(S_awsize),
    .S_awburst(S_awburst), .S_awlock(S_awlock), .S_awcache(S_awcache), .S_awprot(S_awprot),
    .S_awqos(S_awqos), .S_awvalid(S_awvalid), .S_awready(S_awready),
    .M_awid(M_awid), .M_awaddr(M_awaddr), .M_awlen(M_awlen), .M_awsize(M_awsize),
    .M_awburst(M_awburst), .M_awlock(M_awlock), .M_awcache(M_awcache), .M_awprot(M_awprot),
    .M_awqos(M_awqos), .M_awvalid(M_awvalid), .M_awready(M_awready), .Q_Enables(Q_Enables),
    .route_valid(route_valid), .route_sel(route_sel), .route_decerr(route_decerr),
    .route_id(route_id), .route_pop(route_pop),
    .decerr_valid(decerr_valid), .decerr_id(decerr_id)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [0:0]  id;
    int          sel;
    bit          err;
  } aw_t;

  aw_t slice_q[$];
  aw_t route_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_acc = 0;
  bit  last_acc = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Address map lookup: first slot whose masked bits agree wins
  function automatic void ref_decode(input logic [31:0] a, output int sel, output bit err);
    sel = 0;
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (((a ^ m_base[i]) & m_mask[i]) == 32'h0) begin
        sel = i;
        return;
      end
    end
`ifdef AW_DECERR_EN
    err = 1'b1;
`endif
  endfunction

  task automatic cycle_check();
    aw_t h, n;
    logic [3:0] exp_v;
    bit drain, pop_eff, exp_rdy, exp_dv;
    exp_v = 4'b0;
    drain = 1'b0;
    exp_dv = 1'b0;
    if (slice_q.size() != 0) begin
      h = slice_q[0];
      if (!h.err) exp_v[h.sel] = 1'b1;
      exp_dv = h.err;
      drain = h.err || M_awready[h.sel];
      check_eq("m_awaddr", M_awaddr, h.addr);
      check_eq("m_awlen", M_awlen, h.len);
      check_eq("m_awsize", M_awsize, h.size);
      check_eq("m_awburst", M_awburst, h.burst);
      check_eq("m_awlock", M_awlock, h.lock);
      check_eq("m_awcache", M_awcache, h.cache);
      check_eq("m_awprot", M_awprot, h.prot);
      check_eq("m_awqos", M_awqos, h.qos);
      check_eq("m_awid", M_awid, h.id);
      if (h.err) check_eq("decerr_id", decerr_id, h.id);
    end
    check_eq("m_awvalid", M_awvalid, exp_v);
    check_eq("q_enables", Q_Enables, exp_v);
    check_eq("decerr_valid", decerr_valid, exp_dv);
    check_eq("route_valid", route_valid, route_q.size() != 0);
    if (route_q.size() != 0) begin
      check_eq("route_decerr", route_decerr, route_q[0].err);
      check_eq("route_id", route_id, route_q[0].id);
      if (!route_q[0].err) check_eq("route_sel", route_sel, route_q[0].sel);
    end
    pop_eff = route_pop && (route_q.size() != 0);
    exp_rdy = ((slice_q.size() == 0) || drain) && ((route_q.size() < DEPTH) || pop_eff);
    check_eq("s_awready", S_awready, exp_rdy);
    if (drain) void'(slice_q.pop_front());
    if (pop_eff) void'(route_q.pop_front());
    last_acc = S_awvalid && exp_rdy;
    if (last_acc) begin
      n.addr = S_awaddr; n.len = S_awlen; n.size = S_awsize; n.burst = S_awburst;
      n.lock = S_awlock; n.cache = S_awcache; n.prot = S_awprot; n.qos = S_awqos; n.id = S_awid;
      ref_decode(S_awaddr, n.sel, n.err);
      slice_q.push_back(n);
      route_q.push_back(n);
      n_acc++;
    end
  endtask

  // Inputs are already driven at a falling edge; check, then let the rising edge pass
  task automatic run_cycle();
    #1;
    cycle_check();
    @(negedge ACLK);
  endtask

  task automatic set_aw(input logic v, input logic [31:0] a, input logic [7:0] l, input logic [0:0] id);
    S_awvalid = v;
    S_awaddr  = a;
    S_awlen   = l;
    S_awid    = id;
    S_awsize  = 3'($urandom);
    S_awburst = 2'($urandom);
    S_awlock  = 2'($urandom);
    S_awcache = 4'($urandom);
    S_awprot  = 3'($urandom);
    S_awqos   = 4'($urandom);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    #1;
    check_eq("rst_m_awvalid", M_awvalid, 4'b0);
    check_eq("rst_q_enables", Q_Enables, 4'b0);
    check_eq("rst_route_valid", route_valid, 1'b0);
    check_eq("rst_decerr_valid", decerr_valid, 1'b0);
    check_eq("rst_s_awready", S_awready, 1'b0);
    check_eq("rst_m_awaddr", M_awaddr, 32'h0);
    check_eq("rst_m_awlen", M_awlen, 8'h0);
    check_eq("rst_m_awid", M_awid, 1'b0);
    slice_q.delete();
    route_q.delete();
    last_acc = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    M_awready = 4'b0;
    route_pop = 1'b0;
    set_aw(1'b0, 32'h0, 8'h0, 1'b0);
    do_reset();

    // Single AW to slave 1
    M_awready = 4'b0010;
    set_aw(1'b1, 32'h4000_0010, 8'd3, 1'b0);
    run_cycle();
    S_awvalid = 1'b0;
    run_cycle();
    route_pop = 1'b1;
    run_cycle();
    route_pop = 1'b0;

    // Back-to-back to each region, all ready
    M_awready = 4'hF;
    route_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_aw(1'b1, 32'(i) << 30, 8'(i), 1'(i));
      run_cycle();
    end
    S_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();

    // Slave 2 stalled for 5 cycles with a second AW waiting behind it
    M_awready = 4'b1011;
    set_aw(1'b1, 32'h8000_0000, 8'd7, 1'b1);
    run_cycle();
    set_aw(1'b1, 32'h4000_0100, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle();
    M_awready = 4'hF;
    run_cycle();
    S_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();

    // Unmapped address (0x2xxx_xxxx falls in no slot)
    set_aw(1'b1, 32'h2000_0000, 8'd0, 1'b1);
    run_cycle();
    S_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle();

    // Fill the route FIFO, then pop once with a fifth AW pending
    route_pop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (last_acc) set_aw(1'b1, 32'($urandom), 8'($urandom), 1'($urandom));
      run_cycle();
    end
    route_pop = 1'b1;
    run_cycle();
    route_pop = 1'b0;
    S_awvalid = 1'b0;
    run_cycle();
    route_pop = 1'b1;
    for (int i = 0; i < 6; i++) run_cycle();

    // Slice full with three FIFO entries, then reset
    route_pop = 1'b0;
    M_awready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      set_aw(1'b1, 32'h0000_0040 + 32'(i), 8'(i), 1'b0);
      run_cycle();
    end
    S_awvalid = 1'b0;
    M_awready = 4'h0;
    run_cycle();
    check_eq("pre_rst_fifo_cnt", 64'(route_q.size()), 64'd3);
    do_reset();
    M_awready = 4'hF;
    set_aw(1'b1, 32'hC000_0000, 8'd2, 1'b1);
    run_cycle();
    S_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) run_cycle();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (!S_awvalid || last_acc)
        set_aw(($urandom % 4) != 0, 32'($urandom), 8'($urandom), 1'($urandom));
      for (int s = 0; s < 4; s++) M_awready[s] = ($urandom % 4) != 0;
      route_pop = ($urandom % 2) != 0;
      if (($urandom % 700) == 0) do_reset();
      run_cycle();
    end

    check_eq("accepted_some", 64'(n_acc > 500), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
